// File: rtl/imem_loader.sv
// Byte-stream loader that fills the 256-word instruction memory and holds the CPU in reset until done.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   // state  | meaning
   // IDLE   | after reset, waiting for start
   // HDR0   | accept word-count low byte
   // HDR1   | accept word-count high byte, range-check count
   // DATA   | assemble one little-endian word from four bytes
   // WRITE  | one-cycle imem write of the assembled word
   // CKSUM  | accept and compare trailing checksum byte (optional)
   // DONE   | load good, CPU released
   // ERR    | load aborted, CPU held in reset
   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CKSUM, S_DONE, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         count_q, count_d;
   logic [ADDR_W-1:0]   index_q, index_d;
   logic [1:0]          lane_q, lane_d;
   logic [31:0]         word_q, word_d;
   logic                imem_we_q, imem_we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                cpu_rst_n_q, cpu_rst_n_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [ADDR_W:0]     words_q, words_d;
`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0]          cksum_q, cksum_d;
`endif

   logic        hs;
   logic        go_hdr0;
   logic [15:0] count_full;
   logic [15:0] last_idx;

   assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                       (state_q == S_DATA) || (state_q == S_CKSUM);
   assign hs         = byte_valid && byte_ready;
   assign count_full = {byte_in, count_q[7:0]};
   assign last_idx   = count_q - 16'd1;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      index_d     = index_q;
      lane_d      = lane_q;
      word_d      = word_q;
      imem_we_d   = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      cpu_rst_n_d = cpu_rst_n_q;
      done_d      = done_q;
      err_d       = err_q;
      words_d     = words_q;
      go_hdr0     = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_d     = cksum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) go_hdr0 = 1'b1;
         end
         S_HDR0: begin
            if (hs) begin
               count_d[7:0] = byte_in;
               state_d      = S_HDR1;
            end
         end
         S_HDR1: begin
            if (hs) begin
               count_d = count_full;
               if ((count_full == 16'd0) || (count_full > 16'(DEPTH))) begin
                  state_d     = S_ERR;
                  err_d       = 1'b1;
                  cpu_rst_n_d = 1'b0;
               end else begin
                  state_d = S_DATA;
                  index_d = '0;
                  lane_d  = 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
                  cksum_d = 8'd0;
`endif
               end
            end
         end
         S_DATA: begin
            if (hs) begin
               word_d[lane_q*8 +: 8] = byte_in;
               lane_d                = lane_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
               cksum_d               = cksum_q ^ byte_in;
`endif
               if (lane_q == 2'd3) begin
                  state_d   = S_WRITE;
                  imem_we_d = 1'b1;
                  waddr_d   = index_q;
                  wdata_d   = {byte_in, word_q[23:0]};
                  words_d   = words_q + {{ADDR_W{1'b0}}, 1'b1};
               end
            end
         end
         S_WRITE: begin
            if (16'(index_q) == last_idx) begin
`ifdef IMEM_LOADER_CKSUM_EN
               state_d     = S_CKSUM;
`else
               state_d     = S_DONE;
               done_d      = 1'b1;
               cpu_rst_n_d = 1'b1;
`endif
            end else begin
               index_d = index_q + ADDR_W'(1);
               state_d = S_DATA;
            end
         end
         S_CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
            if (hs) begin
               if (byte_in == cksum_q) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  cpu_rst_n_d = 1'b1;
               end else begin
                  state_d     = S_ERR;
                  err_d       = 1'b1;
                  cpu_rst_n_d = 1'b0;
               end
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_DONE, S_ERR: begin
            if (start) go_hdr0 = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Every (re)load restarts the CPU from PC 0 once it is released.
      if (go_hdr0) begin
         state_d     = S_HDR0;
         done_d      = 1'b0;
         err_d       = 1'b0;
         words_d     = '0;
         cpu_rst_n_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         index_q     <= '0;
         lane_q      <= '0;
         word_q      <= '0;
         imem_we_q   <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         cpu_rst_n_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         words_q     <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
         cksum_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         index_q     <= index_d;
         lane_q      <= lane_d;
         word_q      <= word_d;
         imem_we_q   <= imem_we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         done_q      <= done_d;
         err_q       <= err_d;
         words_q     <= words_d;
`ifdef IMEM_LOADER_CKSUM_EN
         cksum_q     <= cksum_d;
`endif
      end
   end

   assign imem_we      = imem_we_q;
   assign imem_waddr   = waddr_q;
   assign imem_wdata   = wdata_q;
   assign cpu_rst_n    = cpu_rst_n_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random word streams compared against a word-list model.
// Honours IMEM_LOADER_CKSUM_EN by appending the XOR trailer byte to every load.
module tb_imem_loader;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [7:0]        byte_in = 8'h00;
   logic              byte_valid = 1'b0;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst_n;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   int errors = 0;
   int checks = 0;

   logic [31:0]       exp_words[$];
   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_we(imem_we),
      .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
      .done(done), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Log every imem write seen by the memory.
   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_waddr);
         wr_data.push_back(imem_wdata);
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      byte_valid = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int n;
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin
         @(negedge clk);
         byte_valid = 1'b0;
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = b;
      n = 0;
      while (!byte_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         checks++; errors++;
         $display("FAIL handshake_timeout: byte_ready=%0b required 1", byte_ready);
      end
      @(posedge clk);
   endtask

   // Stream the header plus exp_words (and trailer when enabled); optionally poke start mid-load.
   task automatic do_load(input int maxgap, input bit poke_start, input bit skip_start);
      logic [7:0]  cks;
      logic [15:0] n;
      cks = 8'h00;
      n   = 16'(exp_words.size());
      if (!skip_start) pulse_start();
      send_byte(n[7:0], maxgap);
      send_byte(n[15:8], maxgap);
      if (poke_start) pulse_start();
      foreach (exp_words[i]) begin
         for (int l = 0; l < 4; l++) begin
            cks = cks ^ exp_words[i][8*l +: 8];
            send_byte(exp_words[i][8*l +: 8], maxgap);
         end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      send_byte(cks, maxgap);
`endif
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (!(done || err) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL end_timeout: done=%0b err=%0b required one of them 1", done, err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({byte_ready, imem_we, imem_waddr, imem_wdata, cpu_rst_n, done, err, words_loaded} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%0b we=%0b addr=%0h data=%0h rstn=%0b done=%0b err=%0b words=%0d required all 0",
                  byte_ready, imem_we, imem_waddr, imem_wdata, cpu_rst_n, done, err, words_loaded);
      end
   endtask

   task automatic test_basic();
      exp_words = '{32'h0000_0013, 32'h0010_0093};
      wr_addr.delete(); wr_data.delete();
      do_load(0, 1'b0, 1'b0);
      wait_end();
      checks++;
      if (wr_addr.size() != 2) begin
         errors++; $display("FAIL basic_write_count: got %0d required 2", wr_addr.size());
      end
      for (int i = 0; i < wr_addr.size() && i < 2; i++) begin
         checks++;
         if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_words[i]) begin
            errors++;
            $display("FAIL basic_write%0d: got %0h@%0h required %0h@%0h", i, wr_data[i], wr_addr[i], exp_words[i], i);
         end
      end
      checks++;
      if (done !== 1'b1 || cpu_rst_n !== 1'b1 || err !== 1'b0 || words_loaded !== 9'd2) begin
         errors++;
         $display("FAIL basic_status: done=%0b rstn=%0b err=%0b words=%0d required 1 1 0 2", done, cpu_rst_n, err, words_loaded);
      end
   endtask

   task automatic test_bad_header();
      logic [15:0] hdr [2];
      hdr[0] = 16'd0;
      hdr[1] = 16'd257;
      for (int h = 0; h < 2; h++) begin
         wr_addr.delete(); wr_data.delete();
         pulse_start();
         send_byte(hdr[h][7:0], 0);
         send_byte(hdr[h][15:8], 0);
         @(negedge clk);
         byte_valid = 1'b0;
         repeat (4) @(negedge clk);
         checks++;
         if (err !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_header_%0d: err=%0b done=%0b rstn=%0b ready=%0b required 1 0 0 0",
                     hdr[h], err, done, cpu_rst_n, byte_ready);
         end
         checks++;
         if (wr_addr.size() != 0) begin
            errors++; $display("FAIL bad_header_%0d_writes: got %0d required 0", hdr[h], wr_addr.size());
         end
      end
   endtask

   task automatic test_full();
      int bad;
      exp_words.delete();
      for (int i = 0; i < DEPTH; i++) exp_words.push_back($urandom);
      wr_addr.delete(); wr_data.delete();
      do_load(2, 1'b0, 1'b0);
      wait_end();
      checks++;
      if (wr_addr.size() != DEPTH) begin
         errors++; $display("FAIL full_write_count: got %0d required %0d", wr_addr.size(), DEPTH);
      end
      bad = 0;
      for (int i = 0; i < wr_addr.size() && i < DEPTH; i++) begin
         checks++;
         if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_words[i]) begin
            errors++;
            if (bad < 5) $display("FAIL full_write%0d: got %0h@%0h required %0h@%0h", i, wr_data[i], wr_addr[i], exp_words[i], i);
            bad++;
         end
      end
      checks++;
      if (done !== 1'b1 || cpu_rst_n !== 1'b1 || words_loaded !== 9'(DEPTH)) begin
         errors++;
         $display("FAIL full_status: done=%0b rstn=%0b words=%0d required 1 1 %0d", done, cpu_rst_n, words_loaded, DEPTH);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] w0;
      w0 = $urandom;
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int l = 0; l < 4; l++) send_byte(w0[8*l +: 8], 0);
      @(negedge clk);
      byte_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (byte_ready !== 1'b0 || cpu_rst_n !== 1'b0 || imem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL midreset_state: ready=%0b rstn=%0b we=%0b done=%0b err=%0b required all 0",
                  byte_ready, cpu_rst_n, imem_we, done, err);
      end
      checks++;
      if (wr_addr.size() != 1 || wr_data[0] !== w0 || wr_addr[0] !== '0) begin
         errors++;
         $display("FAIL midreset_writes: count=%0d required 1 of %0h@0", wr_addr.size(), w0);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_words = '{$urandom, $urandom};
      wr_addr.delete(); wr_data.delete();
      do_load(1, 1'b0, 1'b0);
      wait_end();
      checks++;
      if (wr_addr.size() != 2 || wr_data[0] !== exp_words[0] || wr_data[1] !== exp_words[1] ||
          wr_addr[1] !== ADDR_W'(1) || done !== 1'b1) begin
         errors++;
         $display("FAIL midreset_reload: writes=%0d done=%0b required 2 writes of %0h %0h and done=1",
                  wr_addr.size(), done, exp_words[0], exp_words[1]);
      end
   endtask

   task automatic test_back_to_back();
      // Restart from DONE, poking start during the load; it must be ignored.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || cpu_rst_n !== 1'b0 || words_loaded !== '0 || byte_ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_clear: done=%0b rstn=%0b words=%0d ready=%0b required 0 0 0 1",
                  done, cpu_rst_n, words_loaded, byte_ready);
      end
      exp_words = '{$urandom, $urandom, $urandom};
      wr_addr.delete(); wr_data.delete();
      do_load(1, 1'b1, 1'b1);
      wait_end();
      checks++;
      if (wr_addr.size() != 3 || words_loaded !== 9'd3 || done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_status: writes=%0d words=%0d done=%0b required 3 3 1", wr_addr.size(), words_loaded, done);
      end
      for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
         checks++;
         if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_words[i]) begin
            errors++;
            $display("FAIL b2b_write%0d: got %0h@%0h required %0h@%0h", i, wr_data[i], wr_addr[i], exp_words[i], i);
         end
      end
   endtask

`ifdef IMEM_LOADER_CKSUM_EN
   task automatic test_cksum();
      logic [7:0] trailer [2];
      trailer[0] = 8'h13;
      trailer[1] = 8'h12;
      for (int t = 0; t < 2; t++) begin
         wr_addr.delete(); wr_data.delete();
         pulse_start();
         send_byte(8'h01, 0);
         send_byte(8'h00, 0);
         send_byte(8'h13, 0);
         send_byte(8'h00, 0);
         send_byte(8'h00, 0);
         send_byte(8'h00, 0);
         send_byte(trailer[t], 0);
         @(negedge clk);
         byte_valid = 1'b0;
         wait_end();
         checks++;
         if (done !== (t == 0) || err !== (t == 1) || cpu_rst_n !== (t == 0) || wr_addr.size() != 1) begin
            errors++;
            $display("FAIL cksum_%0h: done=%0b err=%0b rstn=%0b writes=%0d required %0b %0b %0b 1",
                     trailer[t], done, err, cpu_rst_n, wr_addr.size(), t == 0, t == 1, t == 0);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_bad_header();
      test_full();
      test_mid_reset();
      test_back_to_back();
`ifdef IMEM_LOADER_CKSUM_EN
      test_cksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
